// File: rtl/receiver_fsm_if.sv
// Handshake and delivery signals of the CDC receive end, grouped as one bundle.
// Parity signals exist only when CDC_RX_PARITY_EN is defined.
interface receiver_fsm_if #(
    parameter int unsigned DATA_W = 8
);
    logic              req_in;
    logic [DATA_W-1:0] din;
    logic              ack_out;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              busy;
`ifdef CDC_RX_PARITY_EN
    logic              din_par;
    logic              par_err;

    modport slave (
        input  req_in, din, dout_ready, din_par,
        output ack_out, dout, dout_valid, busy, par_err
    );
    modport master (
        output req_in, din, dout_ready, din_par,
        input  ack_out, dout, dout_valid, busy, par_err
    );
`else
    modport slave (
        input  req_in, din, dout_ready,
        output ack_out, dout, dout_valid, busy
    );
    modport master (
        output req_in, din, dout_ready,
        input  ack_out, dout, dout_valid, busy
    );
`endif
endinterface

// File: rtl/receiver_fsm.sv
// Receive end of a 4-phase req/ack CDC handshake with a one-entry holding buffer.
// Optional even-parity checking is enabled by defining CDC_RX_PARITY_EN.
module receiver_fsm #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic           clk,
    input logic           reset,
    receiver_fsm_if.slave bus
);

    typedef enum logic [1:0] {
        RIdle = 2'b00,
        RHold = 2'b01,
        RAck1 = 2'b10
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_q;
    logic [DATA_W-1:0]      dout_q;
    logic                   dout_valid_q;
    logic                   req_sync;
    logic                   can_load;
    logic                   load;

    assign req_sync = sync_q[SYNC_STAGES-1];
    assign can_load = !dout_valid_q || bus.dout_ready;

    // A word is only taken while req_sync is high; a drop in RHold abandons the transfer.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            RIdle: begin
                if (req_sync) begin
                    if (can_load) begin
                        load    = 1'b1;
                        state_d = RAck1;
                    end else begin
                        state_d = RHold;
                    end
                end
            end
            RHold: begin
                if (!req_sync) begin
                    state_d = RIdle;
                end else if (can_load) begin
                    load    = 1'b1;
                    state_d = RAck1;
                end
            end
            RAck1: begin
                if (!req_sync) state_d = RIdle;
            end
            default: state_d = RIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= '0;
            state_q      <= RIdle;
            ack_q        <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.req_in};
            state_q <= state_d;
            // Look-ahead so ack is a clean flop output aligned with the load edge.
            ack_q   <= (state_d == RAck1);
            if (load) begin
                dout_q       <= bus.din;
                dout_valid_q <= 1'b1;
            end else if (dout_valid_q && bus.dout_ready) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

`ifdef CDC_RX_PARITY_EN
    logic par_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            par_err_q <= 1'b0;
        end else if (load) begin
            par_err_q <= par_err_q | (^bus.din ^ bus.din_par);
        end
    end

    assign bus.par_err = par_err_q;
`endif

    assign bus.ack_out    = ack_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = (state_q != RIdle);

endmodule

// File: tb/tb_receiver_fsm.sv
// Bench for receiver_fsm: directed scenarios plus randomized traffic against a
// transfer-level reference model compared on every cycle.
module tb_receiver_fsm;

    localparam int unsigned DW = 8;
    localparam int unsigned SS = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;

    receiver_fsm_if #(.DATA_W(DW)) bus ();

    receiver_fsm #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a word is taken once per high phase of the synchronised
    // request, as soon as the buffer has room; ack mirrors "taken in this phase".
    logic          hist [SS];
    logic          m_taken, m_ack, m_valid, m_busy, m_par;
    logic [DW-1:0] m_dout;

    initial begin
        for (int i = 0; i < SS; i++) hist[i] = 1'b0;
        {m_taken, m_ack, m_valid, m_busy, m_par} = '0;
        m_dout = '0;
    end

    always @(posedge clk) begin
        logic rs, room, take, par_bit;
        rs = hist[SS-1];
        if (reset) begin
            for (int i = 0; i < SS; i++) hist[i] = 1'b0;
            {m_taken, m_ack, m_valid, m_busy, m_par} = '0;
            m_dout = '0;
        end else begin
            room = !m_valid || bus.dout_ready;
            take = rs && !m_taken && room;
`ifdef CDC_RX_PARITY_EN
            par_bit = bus.din_par;
`else
            par_bit = ^bus.din;
`endif
            if (take) begin
                m_dout  = bus.din;
                m_valid = 1'b1;
                if ((^bus.din) != par_bit) m_par = 1'b1;
            end else if (m_valid && bus.dout_ready) begin
                m_valid = 1'b0;
            end
            m_taken = rs && (m_taken || take);
            m_ack   = m_taken;
            m_busy  = rs;
            for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = bus.req_in;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("ack_out", 32'(bus.ack_out), 32'(m_ack));
            check("dout", 32'(bus.dout), 32'(m_dout));
            check("dout_valid", 32'(bus.dout_valid), 32'(m_valid));
            check("busy", 32'(bus.busy), 32'(m_busy));
`ifdef CDC_RX_PARITY_EN
            check("par_err", 32'(bus.par_err), 32'(m_par));
`endif
        end
    end

    // Delivered words and ack pulses observed at the ports.
    logic [DW-1:0] got [$];
    int            ack_rises = 0;
    logic          ack_prev = 1'b0;

    always @(negedge clk) begin
        if (!reset && bus.dout_valid === 1'b1 && bus.dout_ready) got.push_back(bus.dout);
        if (bus.ack_out === 1'b1 && !ack_prev) ack_rises++;
        ack_prev = (bus.ack_out === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_ack(input logic val, input string name);
        int n = 0;
        while (bus.ack_out !== val && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(bus.ack_out), 32'(val));
    endtask

    task automatic send(input logic [DW-1:0] w);
        bus.din    = w;
        bus.req_in = 1'b1;
        wait_ack(1'b1, "send_ack_rise");
        bus.req_in = 1'b0;
        wait_ack(1'b0, "send_ack_fall");
    endtask

    initial begin
        int n;
        bus.req_in     = 1'b0;
        bus.din        = '0;
        bus.dout_ready = 1'b0;
`ifdef CDC_RX_PARITY_EN
        bus.din_par    = 1'b0;
`endif
        do_reset();
        chk_en = 1'b1;
        check("reset_ack", 32'(bus.ack_out), 32'd0);
        check("reset_valid", 32'(bus.dout_valid), 32'd0);
        check("reset_dout", 32'(bus.dout), 32'd0);

        // Basic: ack after SYNC_STAGES+1 edges, single-cycle valid pulse.
        bus.dout_ready = 1'b1;
        bus.din        = 8'hA5;
`ifdef CDC_RX_PARITY_EN
        bus.din_par    = 1'b0;
`endif
        bus.req_in     = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.ack_out !== 1'b1 && n < 20);
        check("rise_latency", 32'(n), 32'd3);
        check("basic_dout", 32'(bus.dout), 32'hA5);
        check("basic_valid", 32'(bus.dout_valid), 32'd1);
        check("model_ack", 32'(m_ack), 32'd1);
        check("model_dout", 32'(m_dout), 32'hA5);
        tick();
        check("valid_pulse", 32'(bus.dout_valid), 32'd0);
        bus.req_in = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.ack_out !== 1'b0 && n < 20);
        check("fall_latency", 32'(n), 32'd3);

        // Backpressure: second word waits until the first is popped.
        bus.dout_ready = 1'b0;
        send(8'h11);
        got.delete();
        bus.din    = 8'h22;
        bus.req_in = 1'b1;
        repeat (6) tick();
        check("hold_ack", 32'(bus.ack_out), 32'd0);
        check("hold_busy", 32'(bus.busy), 32'd1);
        check("hold_dout", 32'(bus.dout), 32'h11);
        bus.dout_ready = 1'b1;
        tick();
        check("bp_ack", 32'(bus.ack_out), 32'd1);
        check("bp_dout", 32'(bus.dout), 32'h22);
        check("bp_valid", 32'(bus.dout_valid), 32'd1);
        check("bp_popped", (got.size() > 0) ? 32'(got[0]) : 32'hFFFF, 32'h11);
        bus.req_in = 1'b0;
        wait_ack(1'b0, "bp_ack_fall");

        // Back-to-back 0..15.
        tick();
        got.delete();
        ack_rises = 0;
        for (int i = 0; i < 16; i++) send(8'(i));
        tick();
        check("b2b_count", 32'(got.size()), 32'd16);
        for (int i = 0; i < 16 && i < got.size(); i++) check("b2b_word", 32'(got[i]), 32'(i));
        check("b2b_acks", 32'(ack_rises), 32'd16);

        // Spurious request while the buffer is full.
        bus.dout_ready = 1'b0;
        send(8'h33);
        ack_rises  = 0;
        bus.din    = 8'h77;
        bus.req_in = 1'b1;
        tick();
        bus.req_in = 1'b0;
        repeat (8) tick();
        check("spur_acks", 32'(ack_rises), 32'd0);
        check("spur_dout", 32'(bus.dout), 32'h33);
        check("spur_busy", 32'(bus.busy), 32'd0);
        bus.dout_ready = 1'b1;
        tick();

        // Reset while acknowledging; the word is delivered again afterwards.
        bus.din    = 8'h44;
        bus.req_in = 1'b1;
        wait_ack(1'b1, "rst_pre_ack");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_ack", 32'(bus.ack_out), 32'd0);
        check("rst_valid", 32'(bus.dout_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        wait_ack(1'b1, "rst_reload");
        check("rst_reload_dout", 32'(bus.dout), 32'h44);
        bus.req_in = 1'b0;
        wait_ack(1'b0, "rst_fall");

`ifdef CDC_RX_PARITY_EN
        do_reset();
        bus.din_par = 1'b0;
        send(8'h03);
        check("par_ok", 32'(bus.par_err), 32'd0);
        bus.din_par = 1'b1;
        send(8'h03);
        check("par_bad", 32'(bus.par_err), 32'd1);
        bus.din_par = 1'b0;
        send(8'h03);
        check("par_sticky", 32'(bus.par_err), 32'd1);
        do_reset();
        check("par_clear", 32'(bus.par_err), 32'd0);
`endif

        // Randomized traffic, including protocol-violating req glitches and resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) bus.req_in = ~bus.req_in;
            bus.din        = 8'($urandom);
            bus.dout_ready = ($urandom_range(1) == 1);
`ifdef CDC_RX_PARITY_EN
            bus.din_par    = ($urandom_range(3) == 0);
`endif
            reset          = ($urandom_range(199) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
